// File: rtl/zap_wb_drain.sv
// Wishbone B3 write master draining the write-buffer FIFO, one buffered store per bus write.
// Optional incrementing-burst chaining of sequential stores is enabled by ZAP_WB_DRAIN_BURST_EN.
module zap_wb_drain #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int EW = DW/8 + AW + DW
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [EW-1:0]   i_fifo_rdata,
    input  logic            i_fifo_empty,
    output logic            o_fifo_ren,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_adr,
    output logic [DW-1:0]   o_wb_dat,
    output logic [DW/8-1:0] o_wb_sel,
    output logic [2:0]      o_wb_cti,
    output logic [1:0]      o_wb_bte,
    input  logic            i_wb_ack,
    input  logic            i_wb_err,
    output logic            o_err,
    output logic [AW-1:0]   o_err_adr,
    input  logic            i_err_clr,
    output logic            o_idle
);
    localparam int SW = DW/8;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;

    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [2:0]      cti_q, cti_d;
    logic            err_q, err_d;
    logic [AW-1:0]   err_adr_q, err_adr_d;
    logic            fifo_ren;
    logic            term;
    logic            chain_ok;

    logic [SW-1:0]   head_sel;
    logic [AW-1:0]   head_adr;
    logic [DW-1:0]   head_dat;

    assign head_dat = i_fifo_rdata[DW-1:0];
    assign head_adr = i_fifo_rdata[DW +: AW];
    assign head_sel = i_fifo_rdata[DW+AW +: SW];

`ifdef ZAP_WB_DRAIN_BURST_EN
    logic [AW-1:0]   nxt_adr;
    assign nxt_adr  = o_wb_adr + AW'(SW);
    // A run never crosses a 1 KB boundary, so a wrapped low field ends the chain.
    assign chain_ok = !i_fifo_empty && (head_adr == nxt_adr) && (nxt_adr[9:0] != 10'd0);
`else
    assign chain_ok = 1'b0;
`endif

    assign term = i_wb_ack | i_wb_err;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        cti_d     = cti_q;
        err_d     = err_q;
        err_adr_d = err_adr_q;
        fifo_ren  = 1'b0;

        if (i_err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!i_fifo_empty) begin
                    fifo_ren = 1'b1;
                    adr_d    = head_adr;
                    dat_d    = head_dat;
                    sel_d    = head_sel;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    cti_d    = CTI_CLASSIC;
                    state_d  = S_BUS;
                end
            end
            S_BUS: begin
                // A new error overrides a same-cycle clear; only the first address is kept.
                if (i_wb_err) begin
                    err_d = 1'b1;
                    if (!err_q) begin
                        err_adr_d = adr_q;
                    end
                end
                if (term) begin
                    if (chain_ok && !i_wb_err) begin
                        fifo_ren = 1'b1;
                        adr_d    = head_adr;
                        dat_d    = head_dat;
                        sel_d    = head_sel;
                        cti_d    = CTI_INCR;
                    end else begin
                        cyc_d    = 1'b0;
                        stb_d    = 1'b0;
                        cti_d    = CTI_CLASSIC;
                        state_d  = S_IDLE;
                    end
                end else if (chain_ok) begin
                    // Head already continues this beat: tag it as the start of a burst.
                    cti_d = CTI_INCR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            cti_q     <= CTI_CLASSIC;
            err_q     <= 1'b0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            cti_q     <= cti_d;
            err_q     <= err_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign o_fifo_ren = fifo_ren;
    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = stb_q;
    assign o_wb_we    = cyc_q;
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_wb_sel   = sel_q;
    assign o_wb_cti   = cti_q;
    assign o_wb_bte   = 2'b00;
    assign o_err      = err_q;
    assign o_err_adr  = err_adr_q;
    assign o_idle     = (state_q == S_IDLE) && i_fifo_empty;

endmodule
